// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serialises one byte per accepted request onto an async UART line.
// Frame = start bit, D0..D7 (LSB first), optional parity bit, 1 or 2 stop bits.
// Baud rate comes from the same 3-bit baud_set code as the byte receiver; the
// chosen divisor is latched together with the byte so a frame in flight cannot
// be disturbed by later input changes.
module uart_byte_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Data,
  input  logic       Send_go,
  input  logic [2:0] baud_set,
  output logic       uart_tx,
  output logic       Tx_Busy,
  output logic       Tx_Done
);

  // Bit period minus one, in Clk cycles, for each supported baud rate.
  localparam logic [19:0] DIV_9600   = 20'(CLK_FREQ / 9600 - 1);
  localparam logic [19:0] DIV_19200  = 20'(CLK_FREQ / 19200 - 1);
  localparam logic [19:0] DIV_38400  = 20'(CLK_FREQ / 38400 - 1);
  localparam logic [19:0] DIV_57600  = 20'(CLK_FREQ / 57600 - 1);
  localparam logic [19:0] DIV_115200 = 20'(CLK_FREQ / 115200 - 1);

  localparam logic HAS_PARITY = (PARITY_EN != 0);
  localparam logic ODD_PARITY = (PARITY_ODD != 0);
  localparam logic TWO_STOPS  = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  data_reg;
  logic [19:0] div_reg;
  logic [19:0] div_sel;
  logic [19:0] cnt;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic        bit_end;
  logic        accept;
  logic        parity_bit;
  logic        tx_next;
  logic        busy_next;
  logic        done_next;

  // Decode the run-time baud selection; unused codes fall back to 9600.
  always_comb begin
    div_sel = DIV_9600;
    case (baud_set)
      3'd0:    div_sel = DIV_9600;
      3'd1:    div_sel = DIV_19200;
      3'd2:    div_sel = DIV_38400;
      3'd3:    div_sel = DIV_57600;
      3'd4:    div_sel = DIV_115200;
      default: div_sel = DIV_9600;
    endcase
  end

  // A bit period ends on the cycle the divider reaches the latched divisor.
  assign bit_end    = (cnt == div_reg);
  assign parity_bit = (^data_reg) ^ ODD_PARITY;

  // Next-state and next-output logic; the line value is computed one edge
  // ahead so uart_tx itself is always a flop output.
  always_comb begin
    state_next = state;
    tx_next    = uart_tx;
    busy_next  = Tx_Busy;
    done_next  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (Send_go && !Tx_Busy) begin
          accept     = 1'b1;
          state_next = START;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          tx_next    = data_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            if (HAS_PARITY) begin
              state_next = PARITY;
              tx_next    = parity_bit;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            tx_next = data_reg[bit_idx + 3'd1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (bit_end && (stop_idx == TWO_STOPS)) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  // FSM state register; reset abandons any frame in progress.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame context: byte and divisor captured on acceptance, plus the bit
  // divider and the data/stop position counters.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      data_reg <= 8'd0;
      div_reg  <= 20'd0;
      cnt      <= 20'd0;
      bit_idx  <= 3'd0;
      stop_idx <= 1'b0;
    end else begin
      if (accept) begin
        data_reg <= Data;
        div_reg  <= div_sel;
      end
      if (state == IDLE || bit_end) begin
        cnt <= 20'd0;
      end else begin
        cnt <= cnt + 20'd1;
      end
      if (accept) begin
        bit_idx <= 3'd0;
      end else if (state == DATA && bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (accept) begin
        stop_idx <= 1'b0;
      end else if (state == STOP && bit_end) begin
        stop_idx <= ~stop_idx;
      end
    end
  end

  // Registered outputs: idle-high line, busy flag and single-cycle done pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      uart_tx <= 1'b1;
      Tx_Busy <= 1'b0;
      Tx_Done <= 1'b0;
    end else begin
      uart_tx <= tx_next;
      Tx_Busy <= busy_next;
      Tx_Done <= done_next;
    end
  end

endmodule
